alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have ports clk, rst, alu_ena, opcode, accum, data, out, zero; one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for every register.
REQ-003 rst  input  1  asynchronous active-high reset; clears all registers.
REQ-004 alu_ena  input  1  capture enable; when 1, the result registers load on the rising edge of clk.
REQ-005 opcode  input  3  operation select.
REQ-006 accum  input  8  accumulator operand.
REQ-007 data  input  8  memory/data operand.
REQ-008 out  output  8  registered ALU result.
REQ-009 zero  output  1  1 when out equals 8'h00.
REQ-010 carry  output  1  registered carry-out of ADD; present only with ALU_CARRY_EN.

Function
REQ-011 Opcode 000 (PASS0): result SHALL be accum.
REQ-012 Opcode 001 (PASS1): result SHALL be accum.
REQ-013 Opcode 010 (ADD): result SHALL be (accum + data) mod 256, with unsigned wrap-around and no saturation.
REQ-014 Opcode 011 (AND): result SHALL be accum & data, bitwise.
REQ-015 Opcode 100 (XOR): result SHALL be accum ^ data, bitwise.
REQ-016 Opcode 101 (PASSD): result SHALL be data.
REQ-017 Opcode 110 (PASS6) and 111 (PASS7): result SHALL be accum.
REQ-018 On a rising clk edge with alu_ena=1, out SHALL load the result selected by opcode, accum and data present at that edge; latency is exactly one cycle.
REQ-019 With alu_ena=0, out (and carry) SHALL hold their previous value regardless of opcode, accum and data.
REQ-020 zero SHALL be combinational from the out register only (~|out); it SHALL NOT depend directly on accum, data or opcode.
REQ-021 Back-to-back enabled cycles SHALL each produce a result one cycle later with no bubbles.
REQ-022 No input value, including X-free all-ones operands, SHALL cause out to become X or to hold stale data while alu_ena=1.

Reset
REQ-023 While rst=1, out SHALL be 8'h00, zero SHALL be 1 and carry (if present) SHALL be 0, independent of clk.
REQ-024 Reset assertion SHALL take effect immediately, including in the middle of an enabled operation; the pending result is discarded.
REQ-025 When rst=1 and alu_ena=1 on the same edge, reset SHALL win.
REQ-026 The first capture after reset release SHALL occur on the first rising clk edge where rst=0 and alu_ena=1.

Configuration
REQ-027 Macro ALU_CARRY_EN defined: port carry SHALL exist; on an enabled edge it SHALL load bit 8 of the 9-bit sum for ADD, and SHALL load 0 for every other opcode.
REQ-028 Macro ALU_CARRY_EN undefined: port carry and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then alu_ena=1, opcode=000, accum=00, data=FF, one edge -> out=00, zero=1; then accum=55 -> out=55, zero=0.
REQ-030 ADD with accum=33, data=AA -> out=DD, zero=0; ADD with accum=FF, data=01 -> out=00, zero=1 (carry=1 with ALU_CARRY_EN).
REQ-031 AND with accum=0F, data=AA -> out=0A; XOR with accum=F0, data=55 -> out=A5; both zero=0.
REQ-032 PASSD with accum=AA, data=00 -> out=00, zero=1; PASSD with accum=00, data=CC -> out=CC, zero=0; PASS6 with accum=FF, data=F0 -> out=FF; PASS7 with accum=CC, data=0F -> out=CC.
REQ-033 Load out=CC, then set alu_ena=0 and change opcode/accum/data for 3 cycles -> out stays CC, zero=0.
REQ-034 Assert rst asynchronously between clk edges while out=DD -> out=00, zero=1 before the next edge; hold alu_ena=1 through release -> capture resumes on the first edge with rst=0.

Source files
------------

// File: rtl/alu.sv
// alu: 8-bit registered ALU with enable-gated capture and a zero flag.
// Optional feature: define ALU_CARRY_EN to add the registered ADD carry-out
// port 'carry'. Without the macro the port and its register do not exist.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_ena,
  input  logic [2:0] opcode,
  input  logic [7:0] accum,
  input  logic [7:0] data,
  output logic [7:0] out,
  output logic       zero
`ifdef ALU_CARRY_EN
  ,
  output logic       carry
`endif
);

  typedef enum logic [2:0] {
    OP_PASS0 = 3'b000,
    OP_PASS1 = 3'b001,
    OP_ADD   = 3'b010,
    OP_AND   = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSD = 3'b101,
    OP_PASS6 = 3'b110,
    OP_PASS7 = 3'b111
  } op_e;

  op_e        op;
  logic [7:0] add_res;
  logic [7:0] result;

  assign op = op_e'(opcode);

`ifdef ALU_CARRY_EN
  logic add_c;
  // 9-bit sum so bit 8 can feed the carry register
  assign {add_c, add_res} = {1'b0, accum} + {1'b0, data};
`else
  // plain 8-bit wrap-around add
  assign add_res = accum + data;
`endif

  // operation select; every unlisted opcode passes the accumulator
  always_comb begin
    result = accum;
    case (op)
      OP_ADD:   result = add_res;
      OP_AND:   result = accum & data;
      OP_XOR:   result = accum ^ data;
      OP_PASSD: result = data;
      default:  result = accum;
    endcase
  end

  // result register: loads on enabled edges, reset wins over enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          out <= 8'h00;
    else if (alu_ena) out <= result;
  end

  // zero flag looks only at the registered result
  assign zero = ~|out;

`ifdef ALU_CARRY_EN
  // carry register: ADD carry-out, cleared by any other enabled opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          carry <= 1'b0;
    else if (alu_ena) carry <= (op == OP_ADD) ? add_c : 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu, expected values hand-computed.
module tb_alu;
  logic       clk;
  logic       rst;
  logic       alu_ena;
  logic [2:0] opcode;
  logic [7:0] accum;
  logic [7:0] data;
  logic [7:0] out;
  logic       zero;
`ifdef ALU_CARRY_EN
  logic       carry;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu dut (
    .clk     (clk),
    .rst     (rst),
    .alu_ena (alu_ena),
    .opcode  (opcode),
    .accum   (accum),
    .data    (data),
    .out     (out),
    .zero    (zero)
`ifdef ALU_CARRY_EN
    ,
    .carry   (carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drive at negedge, sample 1 time unit after the following posedge
  task automatic step(input logic ena, input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    alu_ena = ena; opcode = op; accum = a; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_ena = 1'b0; opcode = 3'b000; accum = 8'h00; data = 8'h00;
    #2;
    chk("reset_out", out, 8'h00);
    chk("reset_zero", {7'b0, zero}, 8'h01);
    // reset wins over an enabled edge
    step(1'b1, 3'b000, 8'h55, 8'h00);
    chk("rst_vs_ena_out", out, 8'h00);
`ifdef ALU_CARRY_EN
    chk("reset_carry", {7'b0, carry}, 8'h00);
`endif
    @(negedge clk); rst = 1'b0;

    step(1'b1, 3'b000, 8'h00, 8'hFF);
    chk("pass0_00", out, 8'h00);
    chk("pass0_00_zero", {7'b0, zero}, 8'h01);
    step(1'b1, 3'b000, 8'h55, 8'hFF);
    chk("pass0_55", out, 8'h55);
    chk("pass0_55_zero", {7'b0, zero}, 8'h00);

    step(1'b1, 3'b010, 8'h33, 8'hAA);
    chk("add_33_aa", out, 8'hDD);
    chk("add_33_aa_zero", {7'b0, zero}, 8'h00);
`ifdef ALU_CARRY_EN
    chk("add_33_aa_carry", {7'b0, carry}, 8'h00);
`endif
    step(1'b1, 3'b010, 8'hFF, 8'h01);
    chk("add_ff_01", out, 8'h00);
    chk("add_ff_01_zero", {7'b0, zero}, 8'h01);
`ifdef ALU_CARRY_EN
    chk("add_ff_01_carry", {7'b0, carry}, 8'h01);
`endif
    step(1'b1, 3'b010, 8'hC8, 8'h64);
    chk("add_c8_64", out, 8'h2C);

    step(1'b1, 3'b011, 8'h0F, 8'hAA);
    chk("and_0f_aa", out, 8'h0A);
    chk("and_zero", {7'b0, zero}, 8'h00);
`ifdef ALU_CARRY_EN
    chk("and_carry_clr", {7'b0, carry}, 8'h00);
`endif
    step(1'b1, 3'b100, 8'hF0, 8'h55);
    chk("xor_f0_55", out, 8'hA5);
    chk("xor_zero", {7'b0, zero}, 8'h00);
    step(1'b1, 3'b001, 8'h3C, 8'hC3);
    chk("pass1_3c", out, 8'h3C);

    step(1'b1, 3'b101, 8'hAA, 8'h00);
    chk("passd_00", out, 8'h00);
    chk("passd_00_zero", {7'b0, zero}, 8'h01);
    step(1'b1, 3'b101, 8'h00, 8'hCC);
    chk("passd_cc", out, 8'hCC);
    chk("passd_cc_zero", {7'b0, zero}, 8'h00);
    step(1'b1, 3'b110, 8'hFF, 8'hF0);
    chk("pass6_ff", out, 8'hFF);
    step(1'b1, 3'b111, 8'hCC, 8'h0F);
    chk("pass7_cc", out, 8'hCC);

    // hold with enable low while inputs churn
    step(1'b0, 3'b010, 8'h11, 8'h22);
    chk("hold1", out, 8'hCC);
    step(1'b0, 3'b101, 8'h00, 8'h00);
    chk("hold2", out, 8'hCC);
    step(1'b0, 3'b100, 8'hCC, 8'hCC);
    chk("hold3", out, 8'hCC);
    chk("hold_zero", {7'b0, zero}, 8'h00);

`ifdef ALU_CARRY_EN
    step(1'b1, 3'b010, 8'h80, 8'h80);
    chk("add_80_80_carry", {7'b0, carry}, 8'h01);
    step(1'b0, 3'b000, 8'h01, 8'h01);
    chk("carry_hold", {7'b0, carry}, 8'h01);
`endif

    // asynchronous reset between edges, enable held through release
    step(1'b1, 3'b010, 8'h33, 8'hAA);
    chk("pre_rst_dd", out, 8'hDD);
    @(negedge clk);
    alu_ena = 1'b1; opcode = 3'b010; accum = 8'h11; data = 8'h22;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 8'h00);
    chk("async_rst_zero", {7'b0, zero}, 8'h01);
    @(posedge clk); #1;
    chk("rst_held_out", out, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("first_after_rel", out, 8'h33);
    chk("first_after_rel_zero", {7'b0, zero}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
